if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL take parameter RESET_PC, default 32'h0000_0000: the PC loaded at reset.
REQ-002 SHALL take parameter ICACHE_IDX_W, default 7: icache index width, giving 2^7 = 128 one-word lines.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port rdy, input, 1 bit: global run enable; 0 freezes all state.
REQ-006 SHALL have port stall_i, input, 1 bit: downstream IF_ID register cannot accept.
REQ-007 SHALL have port jump_enable_i, input, 1 bit: redirect request from EX.
REQ-008 SHALL have port jump_addr_i, input, 32 bits: redirect target.
REQ-009 SHALL have port mc_req_o, output, 1 bit: fetch request to the memory controller (registered).
REQ-010 SHALL have port mc_addr_o, output, 32 bits: fetch word address (registered).
REQ-011 SHALL have port mc_done_i, input, 1 bit: one-cycle pulse, fetch complete.
REQ-012 SHALL have port mc_inst_i, input, 32 bits: fetched word; valid when mc_done_i=1.
REQ-013 SHALL have ports pc_o, output, 32 bits; inst_o, output, 32 bits; inst_valid_o, output, 1 bit: the output slot feeding IF_ID.

Function
REQ-014 SHALL implement a state machine with states IDLE, FETCH and DROP, plus a one-entry output slot {pc_o, inst_o, inst_valid_o}.
REQ-015 SHALL treat the slot as consumed on any edge where inst_valid_o=1 and stall_i=0; slot contents SHALL be held unchanged while stall_i=1.
REQ-016 SHALL treat the slot as free when inst_valid_o=0 or the slot is being consumed this cycle.
REQ-017 In IDLE with slot free and icache miss (or ICACHE_EN undefined): next edge SHALL set state FETCH, mc_req_o=1 and mc_addr_o=pc.
REQ-018 mc_req_o and mc_addr_o SHALL hold stable until the edge sampling mc_done_i=1; mc_req_o SHALL deassert on that edge.
REQ-019 In FETCH on mc_done_i=1 without redirect: slot SHALL be loaded with {pc, mc_inst_i, 1}, pc SHALL become pc+4, state SHALL return to IDLE, giving one-cycle latency from done to inst_valid_o.
REQ-020 In IDLE with slot free and icache hit: slot SHALL be loaded with {pc, line data, 1} and pc SHALL become pc+4 on the same edge, with no memory request.
REQ-021 SHALL never start a fetch while the slot is occupied and not being consumed.
REQ-022 jump_enable_i=1 SHALL have highest priority: pc becomes {jump_addr_i[31:2],2'b00} and inst_valid_o becomes 0 on that edge.
REQ-023 A redirect while FETCH with no done SHALL move the state to DROP; mc_req_o SHALL stay high until done; the returned word SHALL be discarded; the state SHALL then be IDLE.
REQ-024 A redirect coinciding with mc_done_i in FETCH or DROP SHALL discard the word and move to IDLE.
REQ-025 A redirect in DROP without done SHALL update pc and remain in DROP.
REQ-026 pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-027 rdy=0 SHALL hold every register, including outputs and icache, while still honouring rst.

Reset
REQ-028 rst=0 SHALL immediately clear state to IDLE, load pc=RESET_PC, and zero mc_req_o, mc_addr_o, pc_o, inst_o and inst_valid_o.
REQ-029 rst=0 SHALL clear all icache valid bits.
REQ-030 Reset during FETCH SHALL abandon the request; no word SHALL be output after reset release until a new request completes.

Configuration
REQ-031 Macro ICACHE_EN defined SHALL enable a direct-mapped cache with index pc[ICACHE_IDX_W+1:2], tag pc[31:ICACHE_IDX_W+2] and a valid bit per line.
REQ-032 With ICACHE_EN defined, the cache SHALL be filled on every mc_done_i, including discarded DROP words, using the address in mc_addr_o.
REQ-033 ICACHE_EN undefined SHALL remove all cache storage; every instruction SHALL be fetched via the memory controller, and the interface is unchanged.

Verification
REQ-034 Reset release with RESET_PC=0; memory returns done 3 cycles after each request -> mc_addr_o sequence 0,4,8; slot pc_o 0,4,8 with the matching inst_o.
REQ-035 Hold stall_i=1 for 5 cycles with the slot valid -> pc_o and inst_o unchanged, no new mc_req_o rise; the fetch resumes the cycle after stall_i falls.
REQ-036 jump_enable_i=1 to 32'h0000_1003 mid-FETCH -> DROP state, the returned word is not output, the next mc_addr_o is 32'h0000_1000, and inst_valid_o=0 meanwhile.
REQ-037 Redirect coinciding with mc_done_i -> word discarded, next request at the target address.
REQ-038 With ICACHE_EN defined, loop 0->8 via jump twice -> the second pass issues no mc_req_o for 0,4,8 and the slot shows the correct instructions one cycle apart.
REQ-039 Assert rst=0 mid-FETCH, then release -> all outputs zero, and the first mc_addr_o equals RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Walks a program counter, fetches one 32-bit word per PC through a simple
// request/done memory-controller port and presents it in a one-entry output
// slot that feeds the IF_ID pipeline register.
//
// Optional feature: define ICACHE_EN to add a direct-mapped, one-word-per-line
// instruction cache in front of the memory controller. Without the macro
// every instruction goes through the memory controller; ports are identical.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous, active-low reset
//   rdy            global run enable, 0 freezes every register
//   stall_i        downstream IF_ID register cannot accept the slot
//   jump_enable_i  redirect request from EX (highest priority)
//   jump_addr_i    redirect target, low two bits ignored
//   mc_req_o       fetch request, held high until mc_done_i is sampled
//   mc_addr_o      fetch word address, stable while mc_req_o is high
//   mc_done_i      one-cycle pulse, fetch complete
//   mc_inst_i      fetched word, valid with mc_done_i
//   pc_o           slot: address of the instruction
//   inst_o         slot: instruction word
//   inst_valid_o   slot: contents valid
//   state_o        debug view of the fetch FSM (0 IDLE, 1 FETCH, 2 DROP)
//
// Slot handshake: inst_valid_o is the valid, !stall_i is the ready. The slot
// is consumed on every edge with inst_valid_o=1 and stall_i=0; while
// stall_i=1 its contents never change. A new word may be loaded on the same
// edge that consumes the old one.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          ICACHE_IDX_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall_i,
  input  logic        jump_enable_i,
  input  logic [31:0] jump_addr_i,
  output logic        mc_req_o,
  output logic [31:0] mc_addr_o,
  input  logic        mc_done_i,
  input  logic [31:0] mc_inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mc_req_q, mc_req_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_inst_q, slot_inst_d;
  logic        slot_valid_q, slot_valid_d;

  logic        slot_free;
  logic        cache_hit;
  logic [31:0] cache_data;

  // The slot can take a new word if it is empty or is leaving this edge.
  assign slot_free = !slot_valid_q || !stall_i;

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  logic [LINES-1:0]        line_valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];
  logic [ICACHE_IDX_W-1:0] rd_idx;
  logic [ICACHE_IDX_W-1:0] wr_idx;
  logic                    fill;

  assign rd_idx     = pc_q[ICACHE_IDX_W+1:2];
  assign wr_idx     = mc_addr_q[ICACHE_IDX_W+1:2];
  assign cache_hit  = line_valid_q[rd_idx] && (tag_q[rd_idx] == pc_q[31:ICACHE_IDX_W+2]);
  assign cache_data = data_q[rd_idx];

  // Every completed request fills the cache, dropped words included. The
  // fill is qualified by an outstanding request so a late done for a fetch
  // abandoned by reset cannot write a line under the reset address.
  assign fill = rdy && mc_done_i && mc_req_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid_q <= '0;
    end else if (fill) begin
      line_valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is never read while its valid bit is 0.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[wr_idx]  <= mc_addr_q[31:ICACHE_IDX_W+2];
      data_q[wr_idx] <= mc_inst_i;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 32'h0000_0000;
`endif

  // Next-state logic for the fetch FSM, PC, request port and output slot.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mc_req_d     = mc_req_q;
    mc_addr_d    = mc_addr_q;
    slot_pc_d    = slot_pc_q;
    slot_inst_d  = slot_inst_q;
    // Consumption empties the slot unless something below refills it.
    slot_valid_d = slot_valid_q && stall_i;

    if (jump_enable_i) begin
      // A redirect kills the slot and retargets the PC. An outstanding
      // request cannot be withdrawn, so its word is waited for in DROP.
      pc_d         = {jump_addr_i[31:2], 2'b00};
      slot_valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          if (mc_done_i) begin
            state_d  = IDLE;
            mc_req_d = 1'b0;
          end else begin
            state_d  = DROP;
          end
        end
        DROP: begin
          if (mc_done_i) begin
            state_d  = IDLE;
            mc_req_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (slot_free) begin
            if (cache_hit) begin
              slot_pc_d    = pc_q;
              slot_inst_d  = cache_data;
              slot_valid_d = 1'b1;
              pc_d         = pc_q + 32'd4;
            end else begin
              state_d   = FETCH;
              mc_req_d  = 1'b1;
              mc_addr_d = pc_q;
            end
          end
        end
        FETCH: begin
          // The slot was free when this fetch started and nothing else fills
          // it meanwhile, so it is empty here and can take the word at once.
          if (mc_done_i) begin
            state_d      = IDLE;
            mc_req_d     = 1'b0;
            slot_pc_d    = pc_q;
            slot_inst_d  = mc_inst_i;
            slot_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end
        end
        DROP: begin
          if (mc_done_i) begin
            state_d  = IDLE;
            mc_req_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      mc_req_q     <= 1'b0;
      mc_addr_q    <= 32'h0000_0000;
      slot_pc_q    <= 32'h0000_0000;
      slot_inst_q  <= 32'h0000_0000;
      slot_valid_q <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mc_req_q     <= mc_req_d;
      mc_addr_q    <= mc_addr_d;
      slot_pc_q    <= slot_pc_d;
      slot_inst_q  <= slot_inst_d;
      slot_valid_q <= slot_valid_d;
    end
  end

  assign mc_req_o     = mc_req_q;
  assign mc_addr_o    = mc_addr_q;
  assign pc_o         = slot_pc_q;
  assign inst_o       = slot_inst_q;
  assign inst_valid_o = slot_valid_q;
  assign state_o      = state_q;

endmodule
